// File: rtl/cory_rr_pick.sv
// Combinational round-robin picker. Starting one past the last winner, it
// scans the request vector modulo N and returns the first requester it
// finds. Nothing here is specific to the engine arbiter, so other arbiters
// can reuse it.
`ifndef CORY_RR_PICK
`define CORY_RR_PICK

module cory_rr_pick #(
    parameter  int N  = 4,
    localparam int SW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] last,
    output logic          any,
    output logic [SW-1:0] idx
);

    int cand;

    // Scan offsets 1..N from the last winner, so the last winner is checked last.
    always_comb begin
        any  = 1'b0;
        idx  = '0;
        cand = 0;
        for (int i = 1; i <= N; i++) begin
            cand = (int'(last) + i) % N;
            if (!any && req[cand[SW-1:0]]) begin
                any = 1'b1;
                idx = SW'(cand);
            end
        end
    end

endmodule

`endif

// File: rtl/cory_sbd_arb.sv
// Round-robin arbiter that shares one start/busy/done engine among N
// valid/ready requesters. A grant latches the winner's index and payload,
// pulses o_start for one cycle, and then waits for i_done. An optional
// watchdog drops the request if the engine never answers. The requester's
// ready pulse comes straight from i_done, so it lands in the completion cycle.
`ifndef CORY_SBD_ARB
`define CORY_SBD_ARB

module cory_sbd_arb #(
    parameter  int N       = 4,
    parameter  int W       = 32,
    parameter  int TIMEOUT = 1024,
    localparam int SW      = $clog2(N)
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [N-1:0]   i_v,
    input  logic [N*W-1:0] i_d,
    output logic [N-1:0]   o_r,
    output logic           o_start,
    output logic           o_busy,
    output logic [SW-1:0]  o_sel,
    output logic [W-1:0]   o_d,
    input  logic           i_done,
    output logic           o_err
);

    // The watchdog counter is kept one bit wide even when the watchdog is disabled.
    localparam int            CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_BUSY  = 2'd2
    } state_t;

    state_t        state;
    logic [SW-1:0] last;
    logic [CW-1:0] cnt;

    logic          pick_any;
    logic [SW-1:0] pick_idx;
    logic [W-1:0]  pick_d;
    logic          fin_done;
    logic          fin_tmo;

    cory_rr_pick #(.N(N)) u_pick (
        .req  (i_v),
        .last (last),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    // Select the winner's payload slice for latching on the grant.
    always_comb begin
        pick_d = '0;
        for (int k = 0; k < N; k++) begin
            if (pick_idx == SW'(k)) pick_d = i_d[k*W +: W];
        end
    end

    // A done in START counts as completion too (zero-latency engine).
    // The watchdog can only fire from BUSY.
    assign fin_done = ((state == S_START) || (state == S_BUSY)) && i_done;
    assign fin_tmo  = (TIMEOUT != 0) && (state == S_BUSY) && (cnt == CNT_LAST);

    assign o_start  = (state == S_START);
    assign o_busy   = (state != S_IDLE);
    // When done and the timeout land in the same cycle, done wins.
    assign o_err    = fin_tmo && !i_done;

    // Acknowledge the granted requester in the completion cycle. This covers a normal done and a watchdog drop.
    always_comb begin
        o_r = '0;
        if (fin_done || fin_tmo) o_r[o_sel] = 1'b1;
    end

    // Grant/start/busy sequencer with watchdog counter and round-robin pointer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            o_sel <= '0;
            o_d   <= '0;
            last  <= SW'(N - 1);
            cnt   <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (pick_any) begin
                        o_sel <= pick_idx;
                        o_d   <= pick_d;
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (i_done) begin
                        last  <= o_sel;
                        state <= S_IDLE;
                    end else begin
                        cnt   <= '0;
                        state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (fin_done || fin_tmo) begin
                        last  <= o_sel;
                        state <= S_IDLE;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

`endif

// File: tb/tb_cory_sbd_arb.sv
// Directed bench for cory_sbd_arb (N=4, W=32, TIMEOUT=8). A reactive engine
// model answers each o_start after a queued latency. Expected grants
// (sel/payload) are queued when requests are driven and are popped when
// o_start appears.
module tb_cory_sbd_arb;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int TO = 8;
    localparam int SW = 2;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [N-1:0]   i_v;
    logic [N*W-1:0] i_d;
    logic [N-1:0]   o_r;
    logic           o_start;
    logic           o_busy;
    logic [SW-1:0]  o_sel;
    logic [W-1:0]   o_d;
    logic           i_done;
    logic           o_err;

    cory_sbd_arb #(.N(N), .W(W), .TIMEOUT(TO)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .i_v     (i_v),
        .i_d     (i_d),
        .o_r     (o_r),
        .o_start (o_start),
        .o_busy  (o_busy),
        .o_sel   (o_sel),
        .o_d     (o_d),
        .i_done  (i_done),
        .o_err   (o_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          sel;
        logic [W-1:0] d;
    } exp_t;

    exp_t exp_q[$];
    int   lat_q[$];
    int   rlat_q[$];
    int   rcyc_q[$];

    int n_checks = 0;
    int n_errs   = 0;
    int cyc_n    = 0;
    int rcount   = 0;
    int scount   = 0;
    int ecount   = 0;
    int busy_only = 0;
    int cur_sel  = 0;
    int start_cyc = 0;
    int r_hits[N];

    bit       hold    = 1'b0;
    bit       eng_act = 1'b0;
    int       ecnt    = 0;
    int       elat    = -1;
    logic [N-1:0] drop = '0;

    function automatic logic [W-1:0] pay(input int k);
        return 32'hA500_0000 + W'(k) * 32'h0101_1111;
    endfunction

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int k);
        exp_t e;
        e.sel = k;
        e.d   = pay(k);
        exp_q.push_back(e);
    endtask

    // Engine model: i_done fires 'elat' cycles after o_start (-1 = never).
    task automatic eng();
        if (o_start) begin
            eng_act = 1'b1;
            ecnt    = 0;
            elat    = (lat_q.size() > 0) ? lat_q.pop_front() : -1;
        end else if (eng_act) begin
            ecnt++;
        end
        i_done = eng_act && (ecnt == elat);
    endtask

    task automatic mon();
        exp_t e;
        if (o_start) begin
            scount++;
            start_cyc = cyc_n;
            chk("sb_nonempty_at_start", longint'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("o_sel", longint'(o_sel), longint'(e.sel));
                chk("o_d", longint'(o_d), longint'(e.d));
                cur_sel = e.sel;
            end
        end
        if (o_busy && !o_start) busy_only++;
        if (o_r != '0) begin
            rcount++;
            r_hits[cur_sel]++;
            rlat_q.push_back(cyc_n - start_cyc);
            rcyc_q.push_back(cyc_n);
            chk("o_r_onehot", longint'(o_r), longint'(4'b0001 << cur_sel));
            chk("o_r_while_busy", longint'(o_busy), 1);
            eng_act = 1'b0;
            if (!hold) drop = drop | o_r;
        end
        if (o_err) begin
            ecount++;
            chk("o_err_with_o_r", longint'(|o_r), 1);
        end
    endtask

    // One clock: engine reacts after the edge, outputs checked at negedge.
    task automatic cyc();
        eng();
        @(negedge clk);
        cyc_n++;
        mon();
        @(posedge clk);
        #1;
        i_v  = i_v & ~drop;
        drop = '0;
    endtask

    task automatic wait_r(input int n, input int budget, input string tag);
        int tgt;
        tgt = rcount + n;
        for (int i = 0; i < budget && rcount < tgt; i++) cyc();
        chk(tag, longint'(rcount), longint'(tgt));
    endtask

    task automatic wait_start(input int budget, input string tag);
        int tgt;
        tgt = scount + 1;
        for (int i = 0; i < budget && scount < tgt; i++) cyc();
        chk(tag, longint'(scount), longint'(tgt));
    endtask

    task automatic pop_lat(input string tag, input int exp);
        int v;
        v = -1;
        if (rlat_q.size() > 0) v = rlat_q.pop_front();
        chk(tag, longint'(v), longint'(exp));
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        i_v     = '0;
        i_done  = 1'b0;
        eng_act = 1'b0;
        lat_q.delete();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic chk_zero(input string pfx);
        chk({pfx, "_o_r"},     longint'(o_r), 0);
        chk({pfx, "_o_start"}, longint'(o_start), 0);
        chk({pfx, "_o_busy"},  longint'(o_busy), 0);
        chk({pfx, "_o_sel"},   longint'(o_sel), 0);
        chk({pfx, "_o_d"},     longint'(o_d), 0);
        chk({pfx, "_o_err"},   longint'(o_err), 0);
    endtask

    initial begin
        int ebase;
        int rbase;
        int r1;
        int r2;
        reset_n = 1'b0;
        i_v     = '0;
        i_done  = 1'b0;
        i_d     = '0;
        for (int k = 0; k < N; k++) i_d[k*W +: W] = pay(k);
        for (int k = 0; k < N; k++) r_hits[k] = 0;

        // Reset state
        #12;
        chk_zero("rst");
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Single request from requester 2, done 5 cycles after start
        push(2);
        lat_q.push_back(5);
        i_v = 4'b0100;
        wait_r(1, 30, "s1_done");
        chk("s1_busy_low_after", longint'(o_busy), 0);
        pop_lat("s1_latency", 5);

        // All four requesting continuously after reset: 0,1,2,3,0
        do_reset();
        for (int k = 0; k < N; k++) r_hits[k] = 0;
        hold = 1'b1;
        push(0); push(1); push(2); push(3); push(0);
        for (int k = 0; k < 5; k++) lat_q.push_back(2);
        i_v = 4'b1111;
        wait_r(5, 80, "s2_done");
        i_v  = '0;
        hold = 1'b0;
        chk("s2_hits0", longint'(r_hits[0]), 2);
        chk("s2_hits1", longint'(r_hits[1]), 1);
        chk("s2_hits2", longint'(r_hits[2]), 1);
        chk("s2_hits3", longint'(r_hits[3]), 1);
        for (int k = 0; k < 5; k++) pop_lat("s2_latency", 2);

        // Zero-latency engine: done in START, requesters 1 then 0
        rcyc_q.delete();
        busy_only = 0;
        hold = 1'b1;
        push(1); push(0);
        lat_q.push_back(0); lat_q.push_back(0);
        i_v = 4'b0011;
        wait_r(2, 30, "s3_done");
        i_v  = '0;
        hold = 1'b0;
        pop_lat("s3_latency_a", 0);
        pop_lat("s3_latency_b", 0);
        r1 = (rcyc_q.size() > 0) ? rcyc_q.pop_front() : 0;
        r2 = (rcyc_q.size() > 0) ? rcyc_q.pop_front() : 0;
        chk("s3_start_gap", longint'(r2 - r1), 2);
        chk("s3_no_busy_cycle", longint'(busy_only), 0);

        // Watchdog: requester 1 never completes, requester 2 is served next
        ebase = ecount;
        push(1); push(2);
        lat_q.push_back(-1); lat_q.push_back(3);
        i_v = 4'b0110;
        wait_r(2, 60, "s4_done");
        pop_lat("s4_timeout_latency", TO);
        pop_lat("s4_next_latency", 3);
        chk("s4_err_count", longint'(ecount - ebase), 1);

        // Done coincident with the timeout cycle: no error
        ebase = ecount;
        push(3);
        lat_q.push_back(TO);
        i_v = 4'b1000;
        wait_r(1, 30, "s5_done");
        pop_lat("s5_latency", TO);
        chk("s5_err_count", longint'(ecount - ebase), 0);

        // Reset while BUSY, then requester 0 wins first
        rbase = rcount;
        push(0);
        lat_q.push_back(-1);
        i_v = 4'b0001;
        wait_start(20, "s6_start");
        cyc();
        cyc();
        chk("s6_busy_before_reset", longint'(o_busy), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk_zero("s6_async_rst");
        chk("s6_no_o_r", longint'(rcount), longint'(rbase));
        i_v     = '0;
        i_done  = 1'b0;
        eng_act = 1'b0;
        lat_q.delete();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        push(0); push(3);
        lat_q.push_back(1); lat_q.push_back(1);
        i_v = 4'b1001;
        wait_r(2, 30, "s6_after_reset_done");
        pop_lat("s6_latency_a", 1);
        pop_lat("s6_latency_b", 1);
        chk("sb_empty_at_end", longint'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule

// File: doc/cory_sbd_arb.md
# cory_sbd_arb

Round-robin arbiter that shares one start/busy/done processing engine among N valid/ready requesters. Each requester presents a request plus a W-bit payload. The arbiter grants one request at a time, latches its payload, and issues a start pulse to the engine. It returns ready to the granted requester when the engine reports done, or when a watchdog timeout expires. It sits between several producer pipelines and a single shared engine.

## Interface
Parameters:
- N, 4: number of requesters, 2..16.
- W, 32: payload width per requester.
- TIMEOUT, 1024: maximum cycles to wait for i_done after o_start; 0 disables the watchdog.
- SW, $clog2(N): select width, a derived localparam.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- i_v  in  N  request valid per requester; held high until the matching o_r bit is seen.
- i_d  in  N*W  payloads; requester k occupies bits [k*W +: W].
- o_r  out  N  one-cycle ready/acknowledge per requester.
- o_start  out  1  one-cycle start pulse to the engine.
- o_busy  out  1  engine owned by a granted request.
- o_sel  out  SW  index of the granted requester; stable while o_busy is high.
- o_d  out  W  latched payload of the granted requester; stable while o_busy is high.
- i_done  in  1  engine completion pulse.
- o_err  out  1  one-cycle pulse when the watchdog expires.

## Operation
State machine with three states: IDLE, START, BUSY.

IDLE:
- If i_v is nonzero, pick a requester k by round robin. The search begins at last+1 and wraps modulo N.
- Register o_sel=k and o_d=i_d[k], then go to START.
- If i_v is zero, stay in IDLE.

START:
- o_start=1 for exactly this cycle.
- If i_done is high in this cycle, treat it as completion, same as in BUSY.
- Otherwise go to BUSY and clear the watchdog counter.

BUSY:
- If i_done is high: o_r[o_sel]=1 in the same cycle, combinationally from i_done. Set last=o_sel. Go to IDLE.
- If TIMEOUT is nonzero and the counter reaches TIMEOUT-1 without i_done: o_err=1 and o_r[o_sel]=1 in the same cycle, so the request is dropped. Set last=o_sel. Go to IDLE.
- If i_done and the timeout occur in the same cycle, done wins and o_err stays 0.

General rules:
- o_busy = (state != IDLE).
- i_done is ignored in IDLE.
- The watchdog counter is $clog2(TIMEOUT+1) bits wide. It saturates and does not wrap.
- Requester-side i_v deassertion before o_r is a protocol violation; the grant still completes.
- last resets to N-1, so requester 0 wins the first arbitration.
- At most one o_r bit is high in any cycle, and only in the completion cycle.

## Timing
- Reset values: state=IDLE, o_r=0, o_start=0, o_busy=0, o_sel=0, o_d=0, o_err=0, last=N-1, counter=0.
- i_v sampled high in IDLE at cycle t gives o_start and o_busy high at t+1.
- i_done at cycle t+m (m≥1) gives o_r in cycle t+m and o_busy low at t+m+1.
- Back-to-back operation: the next o_start occurs no earlier than t+m+2.
- Maximum latency for any requester is N grants.
- Timeout: with o_start at cycle s, o_err and o_r occur at s+TIMEOUT.
- Reset asserted mid-operation: all state clears immediately. The engine side sees o_busy drop, and no o_r is issued.

## Structure
- No shared package. N, W and TIMEOUT are module parameters. State encodings are localparams.
- One sub-module, cory_rr_pick: a combinational round-robin picker.
  - Inputs: req[N], last[SW].
  - Outputs: any, idx[SW].
  - Also reusable by other arbiters.
- The file is guarded with an include guard for CORY_SBD_ARB.

## Test plan
- Single request, N=4: i_v=0100, i_done 5 cycles after o_start. Required: o_sel=2, o_d=i_d[2], o_r=0100 in the done cycle, o_busy low the next cycle.
- All four requesting continuously: grants come in order 0,1,2,3,0, with each o_r asserted exactly once per grant.
- Zero-latency engine: i_done high in the START cycle. Required: o_r issued in that same cycle, no BUSY cycle, next o_start two cycles later.
- Watchdog with TIMEOUT=8 and i_done never asserted. Required: o_err and o_r[sel] at o_start+8, return to IDLE, and the next requester is served.
- i_done coincident with the timeout cycle: o_r=1 and o_err=0.
- reset_n pulsed low while BUSY: all outputs go to 0 asynchronously. After release, requester 0 wins first.
